// File: rtl/controlador_barrido_display_2d_pkg.sv
// Shared definitions for the two-digit display scan controller:
// state encodings, blank-segment constants and the hex-to-segment table.
package controlador_barrido_display_2d_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BLANK_A = 3'd1,
        SHOW_A  = 3'd2,
        BLANK_B = 3'd3,
        SHOW_B  = 3'd4
    } estado_t;

    localparam logic [6:0] SEG_OFF_ACT_HIGH = 7'h00;
    localparam logic [6:0] SEG_OFF_ACT_LOW  = 7'h7F;

    // Active-high {g,f,e,d,c,b,a}; entry 15 is leftmost, entry 0 rightmost.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] segOff(input logic actLow);
        return actLow ? SEG_OFF_ACT_LOW : SEG_OFF_ACT_HIGH;
    endfunction

endpackage

// File: rtl/controlador_barrido_display_2d_decodificador_hex_7seg.sv
// Combinational hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
module decodificador_hex_7seg
    import controlador_barrido_display_2d_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segmentos
);

    // Plain table lookup; output polarity is the caller's business.
    always_comb begin
        segmentos = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/controlador_barrido_display_2d.sv
// Scan controller for a two-digit 7-segment display fed through a quad
// 2-to-1 mux with active-high disable. Drives the mux select/disable,
// captures the mux output, decodes it and strobes the digits.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | scan stopped, mux disabled, display dark
//   BLANK_A | mux disabled, select on A, waiting BLANK_CYC cycles
//   SHOW_A  | mux enabled on A, digit A shown for DIV_MAX+1 cycles
//   BLANK_B | mux disabled, select on B, waiting BLANK_CYC cycles
//   SHOW_B  | mux enabled on B, digit B shown for DIV_MAX+1 cycles
module controlador_barrido_display_2d
    import controlador_barrido_display_2d_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DIV_MAX     = 49999,
    parameter int BLANK_CYC   = 4,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] Y,
    output logic       S,
    output logic       E,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic [3:0] DIG_A,
    output logic [3:0] DIG_B
);

    localparam logic [DIV_W-1:0] DIV_ULTIMO   = DIV_W'(DIV_MAX);
    localparam logic [3:0]       BLANK_ULTIMO = 4'(BLANK_CYC - 1);
    localparam logic [6:0]       SEG_APAGADO  = segOff(SEG_ACT_LOW);

    estado_t          estado;
    logic [DIV_W-1:0] cntDiv;
    logic [3:0]       cntBlank;
    logic [6:0]       segDecod;
    logic [6:0]       segPol;

    decodificador_hex_7seg uDecod (
        .nibble    (Y),
        .segmentos (segDecod)
    );

    // Apply output polarity once, after the shared active-high decode.
    always_comb begin
        segPol = SEG_ACT_LOW ? ~segDecod : segDecod;
    end

    // Scan FSM: registered S/E follow the next state, AN/SEG/DIG follow the current one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            estado   <= IDLE;
            S        <= 1'b0;
            E        <= 1'b1;
            AN       <= 2'b00;
            SEG      <= SEG_APAGADO;
            DIG_A    <= '0;
            DIG_B    <= '0;
            cntDiv   <= '0;
            cntBlank <= '0;
        end else begin
            // Y is only trusted while the mux was enabled, i.e. in a SHOW state.
            case (estado)
                SHOW_A: begin
                    AN    <= 2'b01;
                    SEG   <= segPol;
                    DIG_A <= Y;
                end
                SHOW_B: begin
                    AN    <= 2'b10;
                    SEG   <= segPol;
                    DIG_B <= Y;
                end
                default: begin
                    AN  <= 2'b00;
                    SEG <= SEG_APAGADO;
                end
            endcase

            if (!EN) begin
                estado <= IDLE;
                S      <= 1'b0;
                E      <= 1'b1;
            end else begin
                case (estado)
                    IDLE: begin
                        estado   <= BLANK_A;
                        S        <= 1'b0;
                        E        <= 1'b1;
                        cntBlank <= '0;
                    end
                    BLANK_A: begin
                        if (cntBlank == BLANK_ULTIMO) begin
                            estado <= SHOW_A;
                            E      <= 1'b0;
                            cntDiv <= '0;
                        end else begin
                            cntBlank <= cntBlank + 1'b1;
                        end
                    end
                    SHOW_A: begin
                        if (cntDiv == DIV_ULTIMO) begin
                            estado   <= BLANK_B;
                            S        <= 1'b1;
                            E        <= 1'b1;
                            cntBlank <= '0;
                        end else begin
                            cntDiv <= cntDiv + 1'b1;
                        end
                    end
                    BLANK_B: begin
                        if (cntBlank == BLANK_ULTIMO) begin
                            estado <= SHOW_B;
                            E      <= 1'b0;
                            cntDiv <= '0;
                        end else begin
                            cntBlank <= cntBlank + 1'b1;
                        end
                    end
                    SHOW_B: begin
                        if (cntDiv == DIV_ULTIMO) begin
                            estado   <= BLANK_A;
                            S        <= 1'b0;
                            E        <= 1'b1;
                            cntBlank <= '0;
                        end else begin
                            cntDiv <= cntDiv + 1'b1;
                        end
                    end
                    default: begin
                        estado <= IDLE;
                        S      <= 1'b0;
                        E      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controlador_barrido_display_2d.sv
// Directed bench for the display scan controller. Two instances share the
// stimulus: one with active-high segments, one with active-low segments.
module tb_controlador_barrido_display_2d;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] aVal;
    logic [3:0] bVal;

    logic       s0, e0, s1, e1;
    logic [3:0] y0, y1;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;
    logic [3:0] digA0, digB0, digA1, digB1;

    int nChecks = 0;
    int nErrors = 0;

    logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    // Quad 2-to-1 mux with active-high disable, one per instance.
    assign y0 = e0 ? 4'h0 : (s0 ? bVal : aVal);
    assign y1 = e1 ? 4'h0 : (s1 ? bVal : aVal);

    controlador_barrido_display_2d #(
        .DIV_W(16), .DIV_MAX(3), .BLANK_CYC(2), .SEG_ACT_LOW(1'b0)
    ) dut0 (
        .CLK(clk), .RST(rst), .EN(en), .Y(y0), .S(s0), .E(e0),
        .SEG(seg0), .AN(an0), .DIG_A(digA0), .DIG_B(digB0)
    );

    controlador_barrido_display_2d #(
        .DIV_W(16), .DIV_MAX(3), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1)
    ) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .Y(y1), .S(s1), .E(e1),
        .SEG(seg1), .AN(an1), .DIG_A(digA1), .DIG_B(digB1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply inputs, take one clock edge, then compare everything just after it.
    task automatic step(input string tag, input logic r, input logic enIn,
                        input logic [3:0] aIn, input logic [3:0] bIn,
                        input logic eS, input logic eE, input logic [1:0] eAN,
                        input logic [6:0] eSeg, input logic [3:0] eDA, input logic [3:0] eDB);
        logic [6:0] segInv;
        segInv = ~eSeg;
        rst  = r;
        en   = enIn;
        aVal = aIn;
        bVal = bIn;
        @(posedge clk);
        #1;
        chk({tag, ".S"},    {31'b0, s0},    {31'b0, eS});
        chk({tag, ".E"},    {31'b0, e0},    {31'b0, eE});
        chk({tag, ".AN"},   {30'b0, an0},   {30'b0, eAN});
        chk({tag, ".SEG"},  {25'b0, seg0},  {25'b0, eSeg});
        chk({tag, ".DIGA"}, {28'b0, digA0}, {28'b0, eDA});
        chk({tag, ".DIGB"}, {28'b0, digB0}, {28'b0, eDB});
        chk({tag, ".SEGn"}, {25'b0, seg1},  {25'b0, segInv});
        chk({tag, ".ANn"},  {30'b0, an1},   {30'b0, eAN});
    endtask

    initial begin
        logic [3:0] aPrev;
        logic [3:0] dbExp;
        logic       eS, eE;
        logic [1:0] eAN;
        logic [6:0] eSeg;
        logic [3:0] eDA, aIn;

        // Reset held with EN high
        step("rst1", 1, 1, 4'h5, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("rst2", 1, 1, 4'h5, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        // First frame: A=5, B=C
        step("s01", 0, 1, 4'h5, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s02", 0, 1, 4'h5, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s03", 0, 1, 4'h5, 4'hC, 0, 0, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s04", 0, 1, 4'h5, 4'hC, 0, 0, 2'b01, 7'h6D, 4'h5, 4'h0);
        step("s05", 0, 1, 4'h5, 4'hC, 0, 0, 2'b01, 7'h6D, 4'h5, 4'h0);
        step("s06", 0, 1, 4'h5, 4'hC, 0, 0, 2'b01, 7'h6D, 4'h5, 4'h0);
        step("s07", 0, 1, 4'h5, 4'hC, 1, 1, 2'b01, 7'h6D, 4'h5, 4'h0);
        step("s08", 0, 1, 4'h5, 4'hC, 1, 1, 2'b00, 7'h00, 4'h5, 4'h0);
        step("s09", 0, 1, 4'h5, 4'hC, 1, 0, 2'b00, 7'h00, 4'h5, 4'h0);
        step("s10", 0, 1, 4'h5, 4'hC, 1, 0, 2'b10, 7'h39, 4'h5, 4'hC);
        step("s11", 0, 1, 4'h5, 4'hC, 1, 0, 2'b10, 7'h39, 4'h5, 4'hC);
        step("s12", 0, 1, 4'h5, 4'hC, 1, 0, 2'b10, 7'h39, 4'h5, 4'hC);
        // Second frame, A changes to F mid SHOW_A
        step("s13", 0, 1, 4'h5, 4'hC, 0, 1, 2'b10, 7'h39, 4'h5, 4'hC);
        step("s14", 0, 1, 4'h5, 4'hC, 0, 1, 2'b00, 7'h00, 4'h5, 4'hC);
        step("s15", 0, 1, 4'h5, 4'hC, 0, 0, 2'b00, 7'h00, 4'h5, 4'hC);
        step("s16", 0, 1, 4'h5, 4'hC, 0, 0, 2'b01, 7'h6D, 4'h5, 4'hC);
        step("s17", 0, 1, 4'hF, 4'hC, 0, 0, 2'b01, 7'h71, 4'hF, 4'hC);
        step("s18", 0, 1, 4'hF, 4'hC, 0, 0, 2'b01, 7'h71, 4'hF, 4'hC);
        step("s19", 0, 1, 4'hF, 4'hC, 1, 1, 2'b01, 7'h71, 4'hF, 4'hC);
        step("s20", 0, 1, 4'hF, 4'hC, 1, 1, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s21", 0, 1, 4'hF, 4'hC, 1, 0, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s22", 0, 1, 4'hF, 4'hC, 1, 0, 2'b10, 7'h39, 4'hF, 4'hC);
        // EN dropped mid SHOW_B, then raised again
        step("s23", 0, 0, 4'hF, 4'hC, 0, 1, 2'b10, 7'h39, 4'hF, 4'hC);
        step("s24", 0, 0, 4'hF, 4'hC, 0, 1, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s25", 0, 0, 4'hF, 4'hC, 0, 1, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s26", 0, 1, 4'hF, 4'hC, 0, 1, 2'b00, 7'h00, 4'hF, 4'hC);
        // A changes during BLANK_A: no effect until SHOW_A
        step("s27", 0, 1, 4'h3, 4'hC, 0, 1, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s28", 0, 1, 4'h3, 4'hC, 0, 0, 2'b00, 7'h00, 4'hF, 4'hC);
        step("s29", 0, 1, 4'h3, 4'hC, 0, 0, 2'b01, 7'h4F, 4'h3, 4'hC);
        // RST pulse mid SHOW_A
        step("s30", 1, 1, 4'h3, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s31", 0, 1, 4'h3, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s32", 0, 1, 4'h3, 4'hC, 0, 1, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s33", 0, 1, 4'h3, 4'hC, 0, 0, 2'b00, 7'h00, 4'h0, 4'h0);
        step("s34", 0, 1, 4'h3, 4'hC, 0, 0, 2'b01, 7'h4F, 4'h3, 4'h0);
        step("s35", 0, 1, 4'h3, 4'hC, 0, 0, 2'b01, 7'h4F, 4'h3, 4'h0);
        step("s36", 0, 1, 4'h3, 4'hC, 0, 0, 2'b01, 7'h4F, 4'h3, 4'h0);

        // Sweep all A values; each frame starts on entry to BLANK_B.
        aPrev = 4'h3;
        dbExp = 4'h0;
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 12; k++) begin
                aIn  = (k == 0) ? aPrev : 4'(v);
                eS   = (k < 6);
                eE   = (k == 0 || k == 1 || k == 6 || k == 7);
                eAN  = 2'b00;
                eSeg = 7'h00;
                eDA  = (k >= 9) ? 4'(v) : aPrev;
                if (k == 3) dbExp = 4'hC;
                if (k == 0) begin
                    eAN  = 2'b01;
                    eSeg = segTab[aPrev];
                end else if (k >= 3 && k <= 6) begin
                    eAN  = 2'b10;
                    eSeg = 7'h39;
                end else if (k >= 9) begin
                    eAN  = 2'b01;
                    eSeg = segTab[v];
                end
                step($sformatf("sw%0d_%0d", v, k), 0, 1, aIn, 4'hC,
                     eS, eE, eAN, eSeg, eDA, dbExp);
            end
            aPrev = 4'(v);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
